// File: rtl/spectrum_bar_encoder.sv
// rtl/spectrum_bar_encoder.sv - per-band peak tracker and thermometer bar encoder for the VGA bar display
module spectrum_bar_encoder #(
    parameter int NUM_BANDS = 16,
    parameter int MAG_W     = 16,
    parameter int SHIFT     = 11,
    parameter int MAX_LEVEL = 18
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mag_valid,
    input  logic [3:0]           mag_band,
    input  logic [MAG_W-1:0]     mag_data,
    input  logic                 frame_done,
    output logic [MAX_LEVEL-1:0] bar0,
    output logic [MAX_LEVEL-1:0] bar1,
    output logic [MAX_LEVEL-1:0] bar2,
    output logic [MAX_LEVEL-1:0] bar3,
    output logic [MAX_LEVEL-1:0] bar4,
    output logic [MAX_LEVEL-1:0] bar5,
    output logic [MAX_LEVEL-1:0] bar6,
    output logic [MAX_LEVEL-1:0] bar7,
    output logic [MAX_LEVEL-1:0] bar8,
    output logic [MAX_LEVEL-1:0] bar9,
    output logic [MAX_LEVEL-1:0] bar10,
    output logic [MAX_LEVEL-1:0] bar11,
    output logic [MAX_LEVEL-1:0] bar12,
    output logic [MAX_LEVEL-1:0] bar13,
    output logic [MAX_LEVEL-1:0] bar14,
    output logic [MAX_LEVEL-1:0] bar15,
    output logic                 bars_update,
    output logic                 overrun
);

    localparam int LVL_W = $clog2(MAX_LEVEL + 1);

    typedef enum logic [1:0] {IDLE, COMMIT, PUBLISH} state_t;

    state_t               state;
    logic [3:0]           cnt;
    logic [MAG_W-1:0]     peak   [NUM_BANDS];
    logic [LVL_W-1:0]     level  [NUM_BANDS];
    logic [LVL_W-1:0]     shadow [NUM_BANDS];
    logic [MAX_LEVEL-1:0] bars   [NUM_BANDS];

    logic [MAG_W-1:0]     raw;
    logic [LVL_W-1:0]     q;
    logic [LVL_W-1:0]     dec;
    logic [LVL_W-1:0]     new_level;

    // Saturate at full width so large peaks cannot wrap into small levels.
    always_comb begin
        raw       = peak[cnt] >> SHIFT;
        q         = (raw > MAG_W'(MAX_LEVEL)) ? LVL_W'(MAX_LEVEL) : LVL_W'(raw);
        dec       = (level[cnt] == '0) ? '0 : level[cnt] - 1'b1;
        new_level = (q > dec) ? q : dec;
    end

    function automatic logic [MAX_LEVEL-1:0] thermo(input logic [LVL_W-1:0] lvl);
        logic [MAX_LEVEL:0] one_hot;
        one_hot = (MAX_LEVEL + 1)'(1) << lvl;
        return MAX_LEVEL'(one_hot - 1'b1);
    endfunction

    // A sample landing on the band being cleared seeds the next frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_BANDS; i++) peak[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_BANDS; i++) begin
                if (state == COMMIT && cnt == 4'(i)) begin
                    peak[i] <= (mag_valid && mag_band == 4'(i)) ? mag_data : '0;
                end else if (mag_valid && mag_band == 4'(i) && mag_data > peak[i]) begin
                    peak[i] <= mag_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            bars_update <= 1'b0;
            overrun     <= 1'b0;
            for (int i = 0; i < NUM_BANDS; i++) begin
                level[i]  <= '0;
                shadow[i] <= '0;
                bars[i]   <= '0;
            end
        end else begin
            bars_update <= 1'b0;
            overrun     <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_done) begin
                        state <= COMMIT;
                        cnt   <= '0;
                    end
                end
                COMMIT: begin
                    shadow[cnt] <= new_level;
                    overrun     <= frame_done;
                    if (cnt == 4'(NUM_BANDS - 1)) state <= PUBLISH;
                    else                          cnt   <= cnt + 1'b1;
                end
                PUBLISH: begin
                    for (int i = 0; i < NUM_BANDS; i++) begin
                        level[i] <= shadow[i];
                        bars[i]  <= thermo(shadow[i]);
                    end
                    bars_update <= 1'b1;
                    overrun     <= frame_done;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bar0  = bars[0];
    assign bar1  = bars[1];
    assign bar2  = bars[2];
    assign bar3  = bars[3];
    assign bar4  = bars[4];
    assign bar5  = bars[5];
    assign bar6  = bars[6];
    assign bar7  = bars[7];
    assign bar8  = bars[8];
    assign bar9  = bars[9];
    assign bar10 = bars[10];
    assign bar11 = bars[11];
    assign bar12 = bars[12];
    assign bar13 = bars[13];
    assign bar14 = bars[14];
    assign bar15 = bars[15];

endmodule

// File: tb/tb_spectrum_bar_encoder.sv
// tb/tb_spectrum_bar_encoder.sv - randomized self-checking bench for spectrum_bar_encoder
module tb_spectrum_bar_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mag_valid = 1'b0;
    logic [3:0]  mag_band = '0;
    logic [15:0] mag_data = '0;
    logic        frame_done = 1'b0;
    logic [17:0] bar0, bar1, bar2, bar3, bar4, bar5, bar6, bar7;
    logic [17:0] bar8, bar9, bar10, bar11, bar12, bar13, bar14, bar15;
    logic        bars_update, overrun;
    logic [17:0] bars [16];

    int vectors = 0;
    int errors  = 0;
    int edge_n  = 0;

    // Model: every accepted sample with its clock edge; each band owns a window of edges per frame.
    int s_edge [$];
    int s_band [$];
    int s_data [$];
    int start_e [16];
    int lvl [16];

    spectrum_bar_encoder dut (
        .clk(clk), .rst(rst), .mag_valid(mag_valid), .mag_band(mag_band),
        .mag_data(mag_data), .frame_done(frame_done),
        .bar0(bar0), .bar1(bar1), .bar2(bar2), .bar3(bar3),
        .bar4(bar4), .bar5(bar5), .bar6(bar6), .bar7(bar7),
        .bar8(bar8), .bar9(bar9), .bar10(bar10), .bar11(bar11),
        .bar12(bar12), .bar13(bar13), .bar14(bar14), .bar15(bar15),
        .bars_update(bars_update), .overrun(overrun)
    );

    assign bars[0]  = bar0;
    assign bars[1]  = bar1;
    assign bars[2]  = bar2;
    assign bars[3]  = bar3;
    assign bars[4]  = bar4;
    assign bars[5]  = bar5;
    assign bars[6]  = bar6;
    assign bars[7]  = bar7;
    assign bars[8]  = bar8;
    assign bars[9]  = bar9;
    assign bars[10] = bar10;
    assign bars[11] = bar11;
    assign bars[12] = bar12;
    assign bars[13] = bar13;
    assign bars[14] = bar14;
    assign bars[15] = bar15;

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        edge_n++;
        if (rst && mag_valid) begin
            s_edge.push_back(edge_n);
            s_band.push_back(int'(mag_band));
            s_data.push_back(int'(mag_data));
        end
        #1;
    endtask

    task automatic drive_rand_sample();
        mag_valid = 1'($urandom_range(1, 0));
        mag_band  = 4'($urandom_range(15, 0));
        mag_data  = 16'($urandom) >> $urandom_range(6, 0);
    endtask

    task automatic model_reset();
        s_edge.delete();
        s_band.delete();
        s_data.delete();
        for (int b = 0; b < 16; b++) begin
            lvl[b]     = 0;
            start_e[b] = edge_n + 1;
        end
    endtask

    // Frame accepted at edge t: band b is committed at edge t+1+b.
    task automatic model_publish(input int t);
        for (int b = 0; b < 16; b++) begin
            int commit_e, pk, qv, dv;
            commit_e = t + 1 + b;
            pk = 0;
            for (int k = 0; k < s_edge.size(); k++)
                if (s_band[k] == b && s_edge[k] >= start_e[b] && s_edge[k] < commit_e && s_data[k] > pk)
                    pk = s_data[k];
            qv = pk / 2048;
            if (qv > 18) qv = 18;
            dv = (lvl[b] > 0) ? lvl[b] - 1 : 0;
            lvl[b] = (qv > dv) ? qv : dv;
            start_e[b] = commit_e;
        end
    endtask

    task automatic idle(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            mag_valid = 1'b0;
            if (rnd) drive_rand_sample();
            step();
            vectors++;
            if (bars_update !== 1'b0 || overrun !== 1'b0) begin
                errors++;
                $display("FAIL idle_pulses: bars_update=%b overrun=%b required 0 0", bars_update, overrun);
            end
        end
        mag_valid = 1'b0;
    endtask

    task automatic run_frame(input int od_at, input int smp_at, input int smp_band,
                             input int smp_data, input bit rnd);
        int t;
        frame_done = 1'b1;
        mag_valid  = 1'b0;
        step();
        t = edge_n;
        for (int i = 1; i <= 17; i++) begin
            mag_valid  = 1'b0;
            frame_done = (i == od_at);
            if (i == smp_at) begin
                mag_valid = 1'b1;
                mag_band  = 4'(smp_band);
                mag_data  = 16'(smp_data);
            end else if (rnd) begin
                drive_rand_sample();
            end
            step();
            vectors++;
            if (bars_update !== 1'(i == 17)) begin
                errors++;
                $display("FAIL bars_update_timing edge T+%0d: got %b required %b", i, bars_update, (i == 17));
            end
            vectors++;
            if (overrun !== 1'(i == od_at)) begin
                errors++;
                $display("FAIL overrun edge T+%0d: got %b required %b", i, overrun, (i == od_at));
            end
        end
        mag_valid  = 1'b0;
        frame_done = 1'b0;
        model_publish(t);
        for (int b = 0; b < 16; b++) begin
            logic [17:0] exp_bar;
            exp_bar = 18'((32'd1 << lvl[b]) - 32'd1);
            vectors++;
            if (bars[b] !== exp_bar) begin
                errors++;
                $display("FAIL frame_bar%0d: got %h required %h", b, bars[b], exp_bar);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_rand_sample();
            frame_done = 1'($urandom_range(1, 0));
            step();
        end
        frame_done = 1'b1;
        step();
        model_reset();
        for (int b = 0; b < 16; b++) begin
            vectors++;
            if (bars[b] !== 18'h00000) begin
                errors++;
                $display("FAIL reset_bar%0d: got %h required 00000", b, bars[b]);
            end
        end
        vectors++;
        if (bars_update !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses: bars_update=%b overrun=%b required 0 0", bars_update, overrun);
        end
        rst        = 1'b1;
        frame_done = 1'b0;
        mag_valid  = 1'b0;
        idle(20, 1'b0);
    endtask

    task automatic test_single_band();
        mag_valid = 1'b1; mag_band = 4'd3; mag_data = 16'h1000;
        step();
        mag_valid = 1'b0;
        idle(2, 1'b0);
        run_frame(0, 0, 0, 0, 1'b0);
        vectors++;
        if (bar3 !== 18'h00003) begin
            errors++;
            $display("FAIL single_band_bar3: got %h required 00003", bar3);
        end
        idle(3, 1'b0);
    endtask

    task automatic test_peak_capture();
        mag_valid = 1'b1; mag_band = 4'd0;
        mag_data = 16'h0800; step();
        mag_data = 16'h3000; step();
        mag_data = 16'h1800; step();
        mag_valid = 1'b0;
        run_frame(0, 0, 0, 0, 1'b0);
        vectors++;
        if (bar0 !== 18'h0003F) begin
            errors++;
            $display("FAIL peak_capture_bar0: got %h required 0003F", bar0);
        end
        idle(3, 1'b0);
    endtask

    task automatic test_saturation_decay();
        logic [17:0] req [3];
        req[0] = 18'h3FFFF; req[1] = 18'h1FFFF; req[2] = 18'h0FFFF;
        mag_valid = 1'b1; mag_band = 4'd15; mag_data = 16'hFFFF;
        step();
        mag_valid = 1'b0;
        for (int f = 0; f < 3; f++) begin
            run_frame(0, 0, 0, 0, 1'b0);
            vectors++;
            if (bar15 !== req[f]) begin
                errors++;
                $display("FAIL saturation_decay_frame%0d_bar15: got %h required %h", f, bar15, req[f]);
            end
            idle(2, 1'b0);
        end
    endtask

    task automatic test_overrun_race();
        run_frame(5, 3, 2, 'h2000, 1'b0);
        vectors++;
        if (bar2 !== 18'h00000) begin
            errors++;
            $display("FAIL race_current_frame_bar2: got %h required 00000", bar2);
        end
        idle(4, 1'b0);
        run_frame(0, 0, 0, 0, 1'b0);
        vectors++;
        if (bar2 !== 18'h0000F) begin
            errors++;
            $display("FAIL race_next_frame_bar2: got %h required 0000F", bar2);
        end
        idle(2, 1'b0);
    endtask

    task automatic test_reset_mid();
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
        for (int i = 1; i < 8; i++) begin
            drive_rand_sample();
            step();
        end
        mag_valid = 1'b0;
        rst = 1'b0;
        step();
        model_reset();
        rst = 1'b1;
        idle(20, 1'b1);
        for (int b = 0; b < 16; b++) begin
            vectors++;
            if (bars[b] !== 18'h00000) begin
                errors++;
                $display("FAIL reset_mid_bar%0d: got %h required 00000", b, bars[b]);
            end
        end
        run_frame(0, 0, 0, 0, 1'b1);
        idle(2, 1'b0);
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 40; f++) begin
            int od;
            od = ($urandom_range(3, 0) == 0) ? int'($urandom_range(17, 1)) : 0;
            idle($urandom_range(8, 0), 1'b1);
            run_frame(od, 0, 0, 0, 1'b1);
        end
        idle(2, 1'b0);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_band();
        test_peak_capture();
        test_saturation_decay();
        test_overrun_race();
        test_reset_mid();
        test_random_frames();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
